// File: rtl/imm_type_decoder.sv
// Decode-stage front end: classifies each fetched instruction by format,
// builds its sign-extended immediate, and presents the decoded result through
// a registered output stage backed by a one-entry skid buffer. in_ready is a
// flop, so it never depends combinationally on out_ready.
module imm_type_decoder #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [ILEN-1:0] in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_inst,
  output logic [XLEN-1:0] out_imm,
  output logic            out_S_type,
  output logic            out_B_type,
  output logic            out_U_type,
  output logic            out_I_type,
  output logic            out_J_type,
  output logic            out_R_type,
  output logic            out_illegal
);

  // One fully decoded instruction; both the output register and the skid
  // entry hold this, so nothing is decoded after the input boundary.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] imm;
    logic            s_type;
    logic            b_type;
    logic            u_type;
    logic            i_type;
    logic            j_type;
    logic            r_type;
    logic            illegal;
  } dec_t;

  // Occupancy is implied by the two valid bits; the enum names it for clarity.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

  dec_t   dec;
  dec_t   out_q, out_d;
  dec_t   skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   in_fire, out_fire;
  state_e state;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // Name the current occupancy from the valid bits.
  always_comb begin
    if (skid_valid_q)     state = ST_FULL;
    else if (out_valid_q) state = ST_BUSY;
    else                  state = ST_EMPTY;
  end

  // Classify the incoming word by opcode and build its immediate.
  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    dec      = '0;
    dec.pc   = in_pc;
    dec.inst = in_inst;
    case (in_inst[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_IMM32, OP_SYSTEM: dec.i_type = 1'b1;
      OP_STORE:                                      dec.s_type = 1'b1;
      OP_BRANCH:                                     dec.b_type = 1'b1;
      OP_LUI, OP_AUIPC:                              dec.u_type = 1'b1;
      OP_JAL:                                        dec.j_type = 1'b1;
      OP_REG, OP_REG32:                              dec.r_type = 1'b1;
      default:                                       dec.illegal = 1'b1;
    endcase

    if (dec.i_type)
      dec.imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
    else if (dec.s_type)
      dec.imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    else if (dec.b_type)
      dec.imm = {{(XLEN-13){in_inst[31]}}, in_inst[31], in_inst[7],
                 in_inst[30:25], in_inst[11:8], 1'b0};
    else if (dec.u_type)
      dec.imm = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
    else if (dec.j_type)
      dec.imm = {{(XLEN-21){in_inst[31]}}, in_inst[31], in_inst[19:12],
                 in_inst[20], in_inst[30:21], 1'b0};
    else
      dec.imm = '0;
  end

  // Next-state for the output register and skid entry; flush wins over all.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            out_d       = dec;
            out_valid_d = 1'b1;
          end
        end
        ST_BUSY: begin
          if (out_fire && in_fire) begin
            out_d = dec;
          end else if (out_fire) begin
            out_valid_d = 1'b0;
          end else if (in_fire) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain of the output can happen;
          // the skid entry moves up ahead of anything newer.
          if (out_fire) begin
            out_d        = skid_q;
            skid_valid_d = 1'b0;
          end
        end
        default: begin
          out_valid_d  = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end

    in_ready_d = ~skid_valid_d;
  end

  // State registers; reset returns to EMPTY with all data cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data registers are reset too, because the visible outputs
      // must read as zero after reset, not just the valid bits.
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_pc      = out_q.pc;
  assign out_inst    = out_q.inst;
  assign out_imm     = out_q.imm;
  assign out_S_type  = out_q.s_type;
  assign out_B_type  = out_q.b_type;
  assign out_U_type  = out_q.u_type;
  assign out_I_type  = out_q.i_type;
  assign out_J_type  = out_q.j_type;
  assign out_R_type  = out_q.r_type;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_type_decoder.sv
// Directed and randomised checks for imm_type_decoder: decode table, latency,
// backpressure through the skid entry, flush, async reset and a scoreboard run.
module tb_imm_type_decoder;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_pc, out_pc, out_imm;
  logic [31:0] in_inst, out_inst;
  logic        out_S_type, out_B_type, out_U_type, out_I_type, out_J_type;
  logic        out_R_type, out_illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imm_type_decoder dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .out_imm(out_imm),
    .out_S_type(out_S_type), .out_B_type(out_B_type), .out_U_type(out_U_type),
    .out_I_type(out_I_type), .out_J_type(out_J_type), .out_R_type(out_R_type),
    .out_illegal(out_illegal)
  );

  // Flag vector order: {S, B, U, I, J, R, illegal}
  localparam logic [6:0] F_S = 7'b1000000;
  localparam logic [6:0] F_B = 7'b0100000;
  localparam logic [6:0] F_U = 7'b0010000;
  localparam logic [6:0] F_I = 7'b0001000;
  localparam logic [6:0] F_J = 7'b0000100;
  localparam logic [6:0] F_R = 7'b0000010;
  localparam logic [6:0] F_X = 7'b0000001;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [63:0] imm;
    logic [6:0]  flags;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [6:0] dut_flags();
    return {out_S_type, out_B_type, out_U_type, out_I_type, out_J_type,
            out_R_type, out_illegal};
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference decode: fields placed at the top of a signed word
  // and arithmetic-shifted down to sign-extend.
  function automatic void ref_decode(input logic [31:0] i,
                                     output logic [63:0] imm,
                                     output logic [6:0] fl);
    logic signed [63:0] t;
    t = '0;
    case (i[6:0])
      7'h13, 7'h03, 7'h67, 7'h1B, 7'h73: begin
        fl = F_I; t = {i[31:20], 52'd0}; imm = t >>> 52;
      end
      7'h23: begin
        fl = F_S; t = {i[31:25], i[11:7], 52'd0}; imm = t >>> 52;
      end
      7'h63: begin
        fl = F_B; t = {i[31], i[7], i[30:25], i[11:8], 1'b0, 51'd0};
        imm = t >>> 51;
      end
      7'h37, 7'h17: begin
        fl = F_U; t = {i[31:12], 44'd0}; imm = t >>> 32;
      end
      7'h6F: begin
        fl = F_J; t = {i[31], i[19:12], i[20], i[30:21], 1'b0, 43'd0};
        imm = t >>> 43;
      end
      7'h33, 7'h3B: begin fl = F_R; imm = '0; end
      default:      begin fl = F_X; imm = '0; end
    endcase
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops[14];
    logic [31:0] r;
    ops = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17,
            7'h6F, 7'h33, 7'h3B, 7'h0B, 7'h7F};
    r = $urandom();
    if ($urandom_range(0, 15) != 0) r[6:0] = ops[$urandom_range(0, 13)];
    return r;
  endfunction

  initial begin
    logic [31:0] got[$];
    logic [63:0] q_pc[$];
    logic [31:0] q_inst[$];
    logic [63:0] e_imm, e_pc, pc_ctr, prev_imm;
    logic [31:0] e_inst, prev_inst;
    logic [6:0]  e_fl;
    logic        c_fire, seen, hold, prev_stall;
    int          sent, rcvd, cyc;

    // Hand-computed decode table.
    vecs[0]  = '{"addi",      32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, F_I};
    vecs[1]  = '{"sw",        32'h00112623, 64'h0000_0000_0000_000C, F_S};
    // beq x0,x0,-4: imm bits {1,1,111111,1110,0} sign-extend to -4
    vecs[2]  = '{"beq",       32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, F_B};
    vecs[3]  = '{"lui",       32'h123450B7, 64'h0000_0000_1234_5000, F_U};
    vecs[4]  = '{"jal",       32'h0000006F, 64'h0000_0000_0000_0000, F_J};
    vecs[5]  = '{"add",       32'h002081B3, 64'h0000_0000_0000_0000, F_R};
    vecs[6]  = '{"custom0",   32'h0000000B, 64'h0000_0000_0000_0000, F_X};
    vecs[7]  = '{"zero",      32'h00000000, 64'h0000_0000_0000_0000, F_X};
    vecs[8]  = '{"lw_neg",    32'h80002083, 64'hFFFF_FFFF_FFFF_F800, F_I};
    vecs[9]  = '{"jal_neg",   32'h8000006F, 64'hFFFF_FFFF_FFF0_0000, F_J};
    vecs[10] = '{"auipc",     32'h00001097, 64'h0000_0000_0000_1000, F_U};
    vecs[11] = '{"csrrw",     32'h30529073, 64'h0000_0000_0000_0305, F_I};
    vecs[12] = '{"op_7f",     32'h0000007F, 64'h0000_0000_0000_0000, F_X};
    vecs[13] = '{"low_bits",  32'h00000092, 64'h0000_0000_0000_0000, F_X};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0;
    #2;
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_in_ready",  64'(in_ready), 1);
    check("rst_imm",       out_imm, 0);
    check("rst_flags",     64'(dut_flags()), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    tick();

    // Back-to-back stream with out_ready=1: one result per cycle, latency 1.
    out_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      check({"stream_in_ready_", vecs[k].name}, 64'(in_ready), 1);
      in_valid = 1'b1;
      in_inst  = vecs[k].inst;
      in_pc    = 64'h8000_0000 + 64'(k * 4);
      tick();
      check({"stream_valid_", vecs[k].name}, 64'(out_valid), 1);
      check({"stream_pc_",    vecs[k].name}, out_pc, 64'h8000_0000 + 64'(k * 4));
      check({"stream_inst_",  vecs[k].name}, 64'(out_inst), 64'(vecs[k].inst));
      check({"stream_imm_",   vecs[k].name}, out_imm, vecs[k].imm);
      check({"stream_flags_", vecs[k].name}, 64'(dut_flags()), 64'(vecs[k].flags));
    end
    in_valid = 1'b0;
    tick();
    check("stream_drained", 64'(out_valid), 0);

    // Backpressure: A to output, B to skid, C held off.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 64'h100; tick();
    in_inst = 32'h00200113; in_pc = 64'h104; tick();
    check("bp_in_ready_full", 64'(in_ready), 0);
    in_inst = 32'h00300193; in_pc = 64'h108; tick();
    tick();
    check("bp_hold_a", 64'(out_inst), 64'h00100093);
    check("bp_still_full", 64'(in_ready), 0);
    out_ready = 1'b1;
    c_fire = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid && out_ready) got.push_back(out_inst);
      if (in_valid && in_ready) c_fire = 1'b1;
      tick();
      if (c_fire) in_valid = 1'b0;
    end
    check("bp_count", 64'(got.size()), 3);
    if (got.size() == 3) begin
      check("bp_order_a", 64'(got[0]), 64'h00100093);
      check("bp_order_b", 64'(got[1]), 64'h00200113);
      check("bp_order_c", 64'(got[2]), 64'h00300193);
    end
    check("bp_empty", 64'(out_valid), 0);

    // Flush in FULL with C offered: nothing survives.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00400213; in_pc = 64'h200; tick();
    in_inst = 32'h00500293; in_pc = 64'h204; tick();
    check("fl_full", 64'(in_ready), 0);
    in_inst = 32'h00600313; in_pc = 64'h208; flush = 1'b1; tick();
    check("fl_out_valid", 64'(out_valid), 0);
    check("fl_in_ready",  64'(in_ready), 1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    seen = 1'b0;
    repeat (5) begin tick(); if (out_valid) seen = 1'b1; end
    check("fl_nothing_emerges", 64'(seen), 0);

    // Flush while an input fires from EMPTY: the input is discarded.
    in_valid = 1'b1; in_inst = 32'h00700393; flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_in_fire_dropped", 64'(out_valid), 0);

    // Async reset mid-cycle from FULL.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'hFFF00093; in_pc = 64'h300; tick();
    in_inst = 32'h00112623; tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 0);
    check("arst_in_ready",  64'(in_ready), 1);
    check("arst_imm",       out_imm, 0);
    check("arst_flags",     64'(dut_flags()), 0);
    @(negedge clk) rst = 1'b0;
    tick();

    // Randomised handshake against a FIFO scoreboard.
    sent = 0; rcvd = 0; cyc = 0; hold = 1'b0; prev_stall = 1'b0;
    pc_ctr = 64'h1_0000; prev_inst = '0; prev_imm = '0;
    while (rcvd < 1000 && cyc < 20000) begin
      if (!hold) begin
        if (sent < 1000 && $urandom_range(0, 9) < 7) begin
          in_valid = 1'b1; in_inst = rand_inst(); in_pc = pc_ctr;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      if (prev_stall) begin
        check("rnd_stall_inst", 64'(out_inst), 64'(prev_inst));
        check("rnd_stall_imm",  out_imm, prev_imm);
      end
      prev_stall = out_valid && !out_ready;
      prev_inst  = out_inst;
      prev_imm   = out_imm;
      if (in_valid && in_ready) begin
        q_pc.push_back(in_pc); q_inst.push_back(in_inst);
        sent++; pc_ctr += 4; hold = 1'b0;
      end else begin
        hold = in_valid;
      end
      if (out_valid && out_ready) begin
        if (q_inst.size() == 0) begin
          check("rnd_unexpected_output", 1, 0);
        end else begin
          e_pc = q_pc.pop_front(); e_inst = q_inst.pop_front();
          ref_decode(e_inst, e_imm, e_fl);
          check("rnd_pc",     out_pc, e_pc);
          check("rnd_inst",   64'(out_inst), 64'(e_inst));
          check("rnd_imm",    out_imm, e_imm);
          check("rnd_flags",  64'(dut_flags()), 64'(e_fl));
          check("rnd_onehot", 64'($countones(dut_flags())), 1);
        end
        rcvd++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check("rnd_received", 64'(rcvd), 1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
